// File: rtl/rs232in_hex_if.sv
// Signal bundle between the RS-232 hex receiver and its consumer.
// master is the receiver side; slave is the consumer / line driver side.
interface rs232in_hex_if;
    logic        serial_in;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [35:0] word_out;
    logic [3:0]  word_digits;
    logic        word_valid;
    logic        framing_error;
    logic        syntax_error;

    modport master (
        input  serial_in,
        output rx_data, rx_valid, word_out, word_digits, word_valid,
               framing_error, syntax_error
    );

    modport slave (
        output serial_in,
        input  rx_data, rx_valid, word_out, word_digits, word_valid,
               framing_error, syntax_error
    );
endinterface

// File: rtl/rs232in_hex.sv
// 8N1 serial receiver plus ASCII hex line parser producing words of up to nine digits.
// Byte pulses one cycle after the stop-bit sample, words one cycle after that; no backpressure.
module rs232in_hex #(
    parameter int frequency = 50_000_000,
    parameter int bps       = 115_200
) (
    input  logic         clock,
    input  logic         reset,
    rs232in_hex_if.master bus
);

    localparam int D  = frequency / bps;
    localparam int H  = D / 2;
    localparam int CW = (D > 2) ? $clog2(D) : 1;
    localparam logic [CW-1:0] LOAD_FULL = CW'(D - 1);
    localparam logic [CW-1:0] LOAD_HALF = CW'(H - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAITHIGH} rx_state_t;

    rx_state_t   state, next_state;
    logic        sync1, rxs;
    logic [CW-1:0] bit_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        tick;
    logic        ld_half, ld_full, clr_idx, shift_en, byte_ok, frame_bad;

    logic [7:0]  rx_data_r;
    logic        rx_valid_r, framing_error_r;
    logic [35:0] acc, word_out_r;
    logic [3:0]  cnt, word_digits_r;
    logic        discard, word_valid_r, syntax_error_r;
    logic [4:0]  dig;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= bus.serial_in;
            rxs   <= sync1;
        end
    end

    assign tick = (bit_cnt == '0);

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (!rxs) next_state = START;
            START:    if (tick) next_state = rxs ? IDLE : DATA;
            DATA:     if (tick && bit_idx == 3'd7) next_state = STOP;
            STOP:     if (tick) next_state = rxs ? IDLE : WAITHIGH;
            WAITHIGH: if (rxs) next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_comb begin
        ld_half   = 1'b0;
        ld_full   = 1'b0;
        clr_idx   = 1'b0;
        shift_en  = 1'b0;
        byte_ok   = 1'b0;
        frame_bad = 1'b0;
        case (state)
            IDLE:  ld_half = !rxs;
            START: if (tick && !rxs) begin
                       ld_full = 1'b1;
                       clr_idx = 1'b1;
                   end
            DATA:  if (tick) begin
                       shift_en = 1'b1;
                       ld_full  = 1'b1;
                   end
            STOP:  if (tick) begin
                       byte_ok   = rxs;
                       frame_bad = !rxs;
                   end
            default: ;
        endcase
    end

    // Counter idles at zero once a sample has been taken; only loads restart it.
    always_ff @(posedge clock) begin
        if (reset) begin
            bit_cnt         <= '0;
            bit_idx         <= '0;
            shreg           <= '0;
            rx_data_r       <= '0;
            rx_valid_r      <= 1'b0;
            framing_error_r <= 1'b0;
        end else begin
            rx_valid_r      <= byte_ok;
            framing_error_r <= frame_bad;
            if (ld_half)             bit_cnt <= LOAD_HALF;
            else if (ld_full)        bit_cnt <= LOAD_FULL;
            else if (bit_cnt != '0)  bit_cnt <= bit_cnt - 1'b1;
            if (clr_idx)       bit_idx <= '0;
            else if (shift_en) bit_idx <= bit_idx + 1'b1;
            if (shift_en)      shreg[bit_idx] <= rxs;
            if (byte_ok)       rx_data_r <= shreg;
        end
    end

    function automatic logic [4:0] hex_nibble(input logic [7:0] b);
        if (b >= 8'h30 && b <= 8'h39)
            return {1'b1, b[3:0]};
        else if ((b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66))
            return {1'b1, 4'(b[3:0] + 4'd9)};
        else
            return 5'd0;
    endfunction

    assign dig = hex_nibble(rx_data_r);

    // A framing error poisons the rest of the line exactly like a bad character.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc            <= '0;
            cnt            <= '0;
            discard        <= 1'b0;
            word_out_r     <= '0;
            word_digits_r  <= '0;
            word_valid_r   <= 1'b0;
            syntax_error_r <= 1'b0;
        end else begin
            word_valid_r   <= 1'b0;
            syntax_error_r <= 1'b0;
            if (framing_error_r) begin
                discard <= 1'b1;
                acc     <= '0;
                cnt     <= '0;
            end else if (rx_valid_r) begin
                if (rx_data_r == 8'd13 || rx_data_r == 8'd10) begin
                    if (!discard && cnt != 4'd0) begin
                        word_out_r    <= acc;
                        word_digits_r <= cnt;
                        word_valid_r  <= 1'b1;
                    end
                    acc     <= '0;
                    cnt     <= '0;
                    discard <= 1'b0;
                end else if (dig[4]) begin
                    if (!discard) begin
                        acc <= {acc[31:0], dig[3:0]};
                        if (cnt != 4'd9) cnt <= cnt + 4'd1;
                    end
                end else begin
                    syntax_error_r <= !discard;
                    discard        <= 1'b1;
                    acc            <= '0;
                    cnt            <= '0;
                end
            end
        end
    end

    assign bus.rx_data       = rx_data_r;
    assign bus.rx_valid      = rx_valid_r;
    assign bus.framing_error = framing_error_r;
    assign bus.word_out      = word_out_r;
    assign bus.word_digits   = word_digits_r;
    assign bus.word_valid    = word_valid_r;
    assign bus.syntax_error  = syntax_error_r;

endmodule
